// File: rtl/fp32_pkg.sv
// fp32_pkg: FP32 field layout, datapath widths and adder FSM states.
// Shared by fp_adder_seq_32bit and its unpack helper.
package fp32_pkg;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int MANT_W = 24;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

   // carry + hidden/frac + guard + round + sticky
   localparam int DP_W = MANT_W + 4;

   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      ADD,
      NORM,
      ROUND,
      DONE
   } fsm_state_t;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

   function automatic logic [DP_W-1:0] fp32_mant(input fp32_t f);
      return (f.exp == '0) ? '0 : {1'b0, 1'b1, f.frac, 3'b000};
   endfunction

endpackage

// File: rtl/fp_adder_seq_32bit_unpack.sv
// fp_adder_seq_32bit_unpack: field split, zero flush, magnitude swap.
// Big operand is the larger {exp,frac}; A wins a tie.
module fp_adder_seq_32bit_unpack
   import fp32_pkg::*;
(
   input  logic [31:0]      a,
   input  logic [31:0]      b,
   output logic             big_sign,
   output logic [EXP_W-1:0] big_exp,
   output logic [EXP_W-1:0] diff,
   output logic [DP_W-1:0]  big_m,
   output logic [DP_W-1:0]  small_m,
   output logic             eff_sub,
   output logic             both_neg
);

   fp32_t fa;
   fp32_t fb;
   logic  a_big;
   logic [EXP_W-1:0] small_exp;

   assign fa = fp32_t'(a);
   assign fb = fp32_t'(b);

   assign a_big = {fa.exp, fa.frac} >= {fb.exp, fb.frac};

   assign big_sign  = a_big ? fa.sign : fb.sign;
   assign big_exp   = a_big ? fa.exp  : fb.exp;
   assign small_exp = a_big ? fb.exp  : fa.exp;
   assign big_m     = a_big ? fp32_mant(fa) : fp32_mant(fb);
   assign small_m   = a_big ? fp32_mant(fb) : fp32_mant(fa);

   assign diff     = big_exp - small_exp;
   assign eff_sub  = fa.sign ^ fb.sign;
   assign both_neg = fa.sign & fb.sign;

endmodule

// File: rtl/fp_adder_seq_32bit.sv
// fp_adder_seq_32bit: multi-cycle FP32 adder, iterative align/normalize.
// Define FP_ADD_ROUND_EN for round-to-nearest-even; truncates otherwise.
module fp_adder_seq_32bit
   import fp32_pkg::*;
#(
   parameter int MAX_ALIGN = 26
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result
);

   localparam logic [EXP_W-1:0] ALIGN_LIM = EXP_W'(MAX_ALIGN);
   localparam logic [EXP_W:0]   EXP_OVF   = {1'b0, EXP_MAX};

   fsm_state_t state, state_n;

   logic             sign_r, sign_n;
   logic             eff_sub_r, eff_sub_n;
   logic             neg_zero_r, neg_zero_n;
   logic [EXP_W:0]   exp_r, exp_n;
   logic [EXP_W-1:0] diff_r, diff_n;
   logic [DP_W-1:0]  big_r, big_n;
   logic [DP_W-1:0]  small_r, small_n;
   logic [DP_W-1:0]  sum_r, sum_n;
   logic [31:0]      res_r, res_n;

   logic             u_sign;
   logic [EXP_W-1:0] u_exp;
   logic [EXP_W-1:0] u_diff;
   logic [DP_W-1:0]  u_big_m;
   logic [DP_W-1:0]  u_small_m;
   logic             u_eff_sub;
   logic             u_both_neg;

   logic [DP_W-1:0]  norm_m;
   logic [EXP_W:0]   norm_e;

   fp_adder_seq_32bit_unpack u_unpack (
      .a        (a),
      .b        (b),
      .big_sign (u_sign),
      .big_exp  (u_exp),
      .diff     (u_diff),
      .big_m    (u_big_m),
      .small_m  (u_small_m),
      .eff_sub  (u_eff_sub),
      .both_neg (u_both_neg)
   );

   // a carry-out folds back one place, keeping the dropped bit as sticky
   always_comb begin
      norm_m = sum_r;
      norm_e = exp_r;
      if (sum_r[DP_W-1]) begin
         norm_m = {1'b0, sum_r[DP_W-1:2], |sum_r[1:0]};
         norm_e = exp_r + 9'd1;
      end
   end

`ifdef FP_ADD_ROUND_EN
   logic              rnd_up;
   logic [MANT_W:0]   rnd_m;
   logic [EXP_W:0]    rnd_e;
   logic [FRAC_W-1:0] rnd_f;

   always_comb begin
      rnd_up = sum_r[2] & (sum_r[1] | sum_r[0] | sum_r[3]);
      rnd_m  = {1'b0, sum_r[DP_W-2:3]} + {{MANT_W{1'b0}}, rnd_up};
      rnd_e  = exp_r;
      rnd_f  = rnd_m[FRAC_W-1:0];
      if (rnd_m[MANT_W]) begin
         rnd_e = exp_r + 9'd1;
         rnd_f = rnd_m[FRAC_W:1];
      end
   end
`endif

   always_comb begin
      state_n    = state;
      sign_n     = sign_r;
      eff_sub_n  = eff_sub_r;
      neg_zero_n = neg_zero_r;
      exp_n      = exp_r;
      diff_n     = diff_r;
      big_n      = big_r;
      small_n    = small_r;
      sum_n      = sum_r;
      res_n      = res_r;

      unique case (state)
         IDLE: begin
            if (in_valid) begin
               sign_n     = u_sign;
               eff_sub_n  = u_eff_sub;
               neg_zero_n = u_both_neg;
               exp_n      = {1'b0, u_exp};
               diff_n     = u_diff;
               big_n      = u_big_m;
               small_n    = u_small_m;
               state_n    = ALIGN;
            end
         end

         ALIGN: begin
            unique case (1'b1)
               diff_r >= ALIGN_LIM: begin
                  small_n = {{(DP_W-1){1'b0}}, |small_r};
                  diff_n  = '0;
                  state_n = ADD;
               end
               diff_r != '0 && diff_r < ALIGN_LIM: begin
                  small_n = {1'b0, small_r[DP_W-1:2], |small_r[1:0]};
                  diff_n  = diff_r - 8'd1;
                  if (diff_r == 8'd1) state_n = ADD;
               end
               default: state_n = ADD;
            endcase
         end

         ADD: begin
            sum_n   = eff_sub_r ? big_r - small_r : big_r + small_r;
            state_n = NORM;
         end

         NORM: begin
            unique case (1'b1)
               sum_r == '0: begin
                  res_n   = {neg_zero_r, 31'd0};
                  state_n = DONE;
               end
               sum_r != '0 && norm_m[DP_W-2]: begin
                  sum_n = norm_m;
                  exp_n = norm_e;
                  if (norm_e >= EXP_OVF) begin
                     res_n   = {sign_r, EXP_MAX, {FRAC_W{1'b0}}};
                     state_n = DONE;
                  end else begin
`ifdef FP_ADD_ROUND_EN
                     state_n = ROUND;
`else
                     res_n   = {sign_r, norm_e[EXP_W-1:0],
                                norm_m[DP_W-3:3]};
                     state_n = DONE;
`endif
                  end
               end
               default: begin
                  if (exp_r <= 9'd1) begin
                     res_n   = {sign_r, 31'd0};
                     state_n = DONE;
                  end else begin
                     sum_n = {sum_r[DP_W-2:0], 1'b0};
                     exp_n = exp_r - 9'd1;
                  end
               end
            endcase
         end

`ifdef FP_ADD_ROUND_EN
         ROUND: begin
            if (rnd_e >= EXP_OVF)
               res_n = {sign_r, EXP_MAX, {FRAC_W{1'b0}}};
            else
               res_n = {sign_r, rnd_e[EXP_W-1:0], rnd_f};
            state_n = DONE;
         end
`endif

         DONE: begin
            if (out_ready) state_n = IDLE;
         end

         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         sign_r     <= 1'b0;
         eff_sub_r  <= 1'b0;
         neg_zero_r <= 1'b0;
         exp_r      <= '0;
         diff_r     <= '0;
         big_r      <= '0;
         small_r    <= '0;
         sum_r      <= '0;
         res_r      <= '0;
      end else begin
         state      <= state_n;
         sign_r     <= sign_n;
         eff_sub_r  <= eff_sub_n;
         neg_zero_r <= neg_zero_n;
         exp_r      <= exp_n;
         diff_r     <= diff_n;
         big_r      <= big_n;
         small_r    <= small_n;
         sum_r      <= sum_n;
         res_r      <= res_n;
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign result    = res_r;

endmodule

// File: tb/tb_fp_adder_seq_32bit.sv
// tb_fp_adder_seq_32bit: directed vectors for the sequential FP32 adder.
// Expected sums and latencies are hand-computed.
module tb_fp_adder_seq_32bit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;

   int vectors = 0;
   int miscompares = 0;

`ifdef FP_ADD_ROUND_EN
   localparam int RL = 1;
   localparam logic [31:0] RNE_EVEN = 32'h3F800002;
   localparam logic [31:0] RNE_CARRY = 32'h40000000;
`else
   localparam int RL = 0;
   localparam logic [31:0] RNE_EVEN = 32'h3F800001;
   localparam logic [31:0] RNE_CARRY = 32'h3FFFFFFF;
`endif

   fp_adder_seq_32bit #(.MAX_ALIGN(26)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // latency counts the accept cycle as cycle 1
   task automatic op(input string tag, input logic [31:0] va,
                     input logic [31:0] vb, input logic [31:0] exp_res,
                     input int exp_lat, input logic release_out);
      int edges;
      a = va;
      b = vb;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      edges = 1;
      while (!out_valid && edges < 200) begin
         @(posedge clk);
         #1;
         edges++;
      end
      chk({tag, " valid"}, 32'(out_valid), 32'd1);
      chk({tag, " res"}, result, exp_res);
      chk({tag, " lat"}, 32'(edges + 1), 32'(exp_lat));
      if (release_out) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst result", result, 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      op("1+1", 32'h3F800000, 32'h3F800000, 32'h40000000, 5 + RL, 1'b1);
      op("1.5-1", 32'h3FC00000, 32'hBF800000, 32'h3F000000, 6 + RL, 1'b1);
      op("diff30", 32'h3F800000, 32'h30800000, 32'h3F800000, 5 + RL, 1'b1);
      op("diff26", 32'h3F800000, 32'h32800000, 32'h3F800000, 5 + RL, 1'b1);
      op("diff25", 32'h3F800000, 32'h33000000, 32'h3F800000, 29 + RL, 1'b1);
      op("ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 5, 1'b1);
      op("3-3", 32'h40400000, 32'hC0400000, 32'h00000000, 5, 1'b1);
      op("-0+-0", 32'h80000000, 32'h80000000, 32'h80000000, 5, 1'b1);
      op("2+1", 32'h40000000, 32'h3F800000, 32'h40400000, 5 + RL, 1'b1);
      op("1+.125", 32'h3F800000, 32'h3E000000, 32'h3F900000, 7 + RL, 1'b1);
      op("-1+2", 32'hBF800000, 32'h40000000, 32'h3F800000, 6 + RL, 1'b1);
      op("undf", 32'h00800000, 32'h80800001, 32'h80000000, 5, 1'b1);
      op("rne", 32'h3F800001, 32'h33800000, RNE_EVEN, 28 + RL, 1'b1);
      op("rcarry", 32'h3FFFFFFF, 32'h33800000, RNE_CARRY, 28 + RL, 1'b1);

      out_ready = 1'b0;
      op("bp", 32'h40000000, 32'h3F800000, 32'h40400000, 5 + RL, 1'b0);
      for (int i = 0; i < 5; i++) begin
         in_valid = (i < 2);
         a = 32'h3F800000;
         b = 32'h3F800000;
         @(posedge clk);
         #1;
         chk("bp out_valid", 32'(out_valid), 32'd1);
         chk("bp result", result, 32'h40400000);
         chk("bp in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp rel in_ready", 32'(in_ready), 32'd1);
      chk("bp rel out_valid", 32'(out_valid), 32'd0);
      op("after bp", 32'h3FC00000, 32'hBF800000, 32'h3F000000, 6 + RL, 1'b1);

      a = 32'h3FC00000;
      b = 32'hBF800000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("mid rst out_valid", 32'(out_valid), 32'd0);
      chk("mid rst in_ready", 32'(in_ready), 32'd1);
      chk("mid rst result", result, 32'h0);
      op("post rst", 32'h3F800000, 32'h3F800000, 32'h40000000, 5 + RL, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
